regfile_wb_arbiter: RTL

Write-back arbiter and scoreboard for the 16-entry, one-write-port register file. Two write-back requesters (ALU and load unit) share the single write port through a round-robin valid/ready handshake. The block registers the winning write onto the register file's rd_addr/reg_write/rd_data inputs. It keeps a busy bit per register so issue logic can stall on pending writes.

---
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for a 16-entry register file with a per-register
// pending-write scoreboard, illegal-address flag and committed-write counter.
module regfile_wb_arbiter #(
    parameter int NREG = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb0_valid,
    input  logic [4:0]       wb0_addr,
    input  logic [31:0]      wb0_data,
    output logic             wb0_ready,
    input  logic             wb1_valid,
    input  logic [4:0]       wb1_addr,
    input  logic [31:0]      wb1_data,
    output logic             wb1_ready,
    input  logic             rsv_valid,
    input  logic [4:0]       rsv_addr,
    input  logic             flush,
    output logic [4:0]       rd_addr,
    output logic             reg_write,
    output logic [31:0]      rd_data,
    output logic [NREG-1:0]  busy,
    output logic             err,
    output logic [15:0]      wb_count
);

    function automatic logic addr_writable(input logic [4:0] addr);
        return (addr[4] == 1'b0) && (addr[3:0] != 4'd0);
    endfunction

    function automatic logic addr_illegal(input logic [4:0] addr);
        return addr[4];
    endfunction

    logic             last_grant_r;   // 1'b0 = wb0 granted last, 1'b1 = wb1
    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic [4:0]       win_addr_s;
    logic [31:0]      win_data_s;
    logic [4:0]       rd_addr_r;
    logic             reg_write_r;
    logic [31:0]      rd_data_r;
    logic [NREG-1:0]  busy_r;
    logic [NREG-1:0]  busy_next_s;
    logic             err_r;
    logic             err_set_s;
    logic [15:0]      wb_count_r;

    // Grant selection: depends only on the valids and the last winner.
    always_comb begin
        grant0_s   = 1'b0;
        grant1_s   = 1'b0;
        win_addr_s = 5'd0;
        win_data_s = 32'd0;
        if (wb0_valid && (!wb1_valid || last_grant_r)) begin
            grant0_s   = 1'b1;
            win_addr_s = wb0_addr;
            win_data_s = wb0_data;
        end else if (wb1_valid) begin
            grant1_s   = 1'b1;
            win_addr_s = wb1_addr;
            win_data_s = wb1_data;
        end else begin
            grant0_s = 1'b0;
        end
        accept_s = grant0_s || grant1_s;
    end

    // Scoreboard next state: commit clears, reservation wins over commit, flush wins over all.
    always_comb begin
        busy_next_s = busy_r;
        err_set_s   = 1'b0;
        if (reg_write_r) begin
            busy_next_s[rd_addr_r[3:0]] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (rsv_valid && addr_writable(rsv_addr)) begin
            busy_next_s[rsv_addr[3:0]] = 1'b1;
        end else if (rsv_valid && addr_illegal(rsv_addr)) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end
        if (accept_s && addr_illegal(win_addr_s)) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = err_set_s;
        end
        if (flush) begin
            busy_next_s = {NREG{1'b0}};
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // Last-winner register, updated only when something is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= grant1_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Output stage toward the register file write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_r   <= 5'd0;
            rd_data_r   <= 32'd0;
            reg_write_r <= 1'b0;
        end else if (accept_s && addr_writable(win_addr_s)) begin
            rd_addr_r   <= win_addr_s;
            rd_data_r   <= win_data_s;
            reg_write_r <= 1'b1;
        end else begin
            reg_write_r <= 1'b0;
        end
    end

    // Scoreboard, sticky error flag and committed-write counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r     <= {NREG{1'b0}};
            err_r      <= 1'b0;
            wb_count_r <= 16'd0;
        end else begin
            busy_r     <= busy_next_s;
            err_r      <= err_r || err_set_s;
            wb_count_r <= reg_write_r ? (wb_count_r + 16'd1) : wb_count_r;
        end
    end

    assign wb0_ready = grant0_s;
    assign wb1_ready = grant1_s;
    assign rd_addr   = rd_addr_r;
    assign rd_data   = rd_data_r;
    assign reg_write = reg_write_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign wb_count  = wb_count_r;

endmodule
